// File: rtl/alu_issue_decoder.sv
// RV32I ALU-lane decoder feeding a DEPTH-entry micro-op FIFO; optional push counters via ALU_ISSUE_DECODER_STATS_EN.
// Latency 1 cycle in->head; in_ready drops only when full (no full-bypass), head held while out_ready is low.
module alu_issue_decoder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int OP    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_instr,
  input  logic [WIDTH-1:0]         in_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OP-1:0]            out_op,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [4:0]               out_rd,
  output logic [WIDTH-1:0]         out_imm,
  output logic                     out_use_imm,
  output logic [4:0]               out_shamt,
  output logic                     out_illegal,
  output logic [WIDTH-1:0]         out_pc,
  output logic [$clog2(DEPTH):0]   count
`ifdef ALU_ISSUE_DECODER_STATS_EN
  ,
  output logic [31:0]              stat_decoded,
  output logic [31:0]              stat_illegal
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [OP-1:0] OP_ADD = OP'(0);
  localparam logic [OP-1:0] OP_SUB = OP'(1);
  localparam logic [OP-1:0] OP_SLL = OP'(2);
  localparam logic [OP-1:0] OP_SRL = OP'(4);
  localparam logic [OP-1:0] OP_SRA = OP'(5);
  localparam logic [OP-1:0] OP_XOR = OP'(6);
  localparam logic [OP-1:0] OP_OR  = OP'(7);
  localparam logic [OP-1:0] OP_AND = OP'(8);
  localparam logic [OP-1:0] OP_BEQ = OP'(9);
  localparam logic [OP-1:0] OP_BNE = OP'(10);
  localparam logic [OP-1:0] OP_BLT = OP'(11);
  localparam logic [OP-1:0] OP_BGE = OP'(12);
  localparam logic [OP-1:0] OP_SLT = OP'(13);

  typedef struct packed {
    logic [OP-1:0]    op;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [WIDTH-1:0] imm;
    logic             use_imm;
    logic [4:0]       shamt;
    logic             illegal;
    logic [WIDTH-1:0] pc;
  } uop_t;

  // funct3 map shared by R-type and I-type; alt picks sub/sra.
  function automatic logic [OP-1:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  alu_op = alt ? OP_SUB : OP_ADD;
      3'b001:  alu_op = OP_SLL;
      3'b010:  alu_op = OP_SLT;
      3'b100:  alu_op = OP_XOR;
      3'b101:  alu_op = alt ? OP_SRA : OP_SRL;
      3'b110:  alu_op = OP_OR;
      3'b111:  alu_op = OP_AND;
      default: alu_op = OP_ADD;
    endcase
  endfunction

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       f7_ok;
  uop_t       dec;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign f7_ok  = (f7 == 7'b0000000) ||
                  (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));

  always_comb begin
    dec         = '0;
    dec.rs1     = in_instr[19:15];
    dec.rs2     = in_instr[24:20];
    dec.rd      = in_instr[11:7];
    dec.pc      = in_pc;
    dec.illegal = 1'b1;
    case (opcode)
      7'b0110011: begin
        if (f7_ok && f3 != 3'b011) begin
          dec.illegal = 1'b0;
          dec.op      = alu_op(f3, f7[5]);
        end
      end
      7'b0010011: begin
        if (f3 != 3'b011) begin
          dec.illegal = 1'b0;
          dec.use_imm = 1'b1;
          dec.op      = alu_op(f3, (f3 == 3'b101) && in_instr[30]);
          dec.imm     = {{(WIDTH-12){in_instr[31]}}, in_instr[31:20]};
          if (f3 == 3'b001 || f3 == 3'b101) dec.shamt = in_instr[24:20];
        end
      end
      7'b1100011: begin
        if (f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b101) begin
          dec.illegal = 1'b0;
          dec.rd      = 5'd0;
          dec.imm     = {{(WIDTH-13){in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
          case (f3)
            3'b000:  dec.op = OP_BEQ;
            3'b001:  dec.op = OP_BNE;
            3'b100:  dec.op = OP_BLT;
            default: dec.op = OP_BGE;
          endcase
        end
      end
      default: ;
    endcase
  end

  uop_t          mem_q [DEPTH];
  uop_t          mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push, pop;

  assign in_ready  = (count_q != CW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = dec;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop) count_d = count_q + CW'(1);
      else if (!push && pop) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  uop_t head;
  assign head        = mem_q[rd_ptr_q];
  assign out_op      = head.op;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_rd      = head.rd;
  assign out_imm     = head.imm;
  assign out_use_imm = head.use_imm;
  assign out_shamt   = head.shamt;
  assign out_illegal = head.illegal;
  assign out_pc      = head.pc;
  assign count       = count_q;

`ifdef ALU_ISSUE_DECODER_STATS_EN
  // Counters survive flush: they measure accepted traffic, not queue contents.
  logic [31:0] stat_decoded_q, stat_decoded_d, stat_illegal_q, stat_illegal_d;

  always_comb begin
    stat_decoded_d = stat_decoded_q;
    stat_illegal_d = stat_illegal_q;
    if (push && !dec.illegal) stat_decoded_d = stat_decoded_q + 32'd1;
    if (push && dec.illegal)  stat_illegal_d = stat_illegal_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_decoded_q <= '0;
      stat_illegal_q <= '0;
    end else begin
      stat_decoded_q <= stat_decoded_d;
      stat_illegal_q <= stat_illegal_d;
    end
  end

  assign stat_decoded = stat_decoded_q;
  assign stat_illegal = stat_illegal_q;
`endif
endmodule

// File: tb/tb_alu_issue_decoder.sv
// Randomized bench for alu_issue_decoder: queue-based reference model decoding from the RV32I field rules.
module tb_alu_issue_decoder;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_imm, out_pc;
  logic [3:0]  out_op;
  logic [4:0]  out_rs1, out_rs2, out_rd, out_shamt;
  logic        out_use_imm, out_illegal;
  logic [2:0]  count;
`ifdef ALU_ISSUE_DECODER_STATS_EN
  logic [31:0] stat_decoded, stat_illegal;
`endif

  always #5 clk = ~clk;

  alu_issue_decoder #(.DEPTH(DEPTH), .WIDTH(32), .OP(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_op(out_op),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_use_imm(out_use_imm), .out_shamt(out_shamt), .out_illegal(out_illegal),
    .out_pc(out_pc), .count(count)
`ifdef ALU_ISSUE_DECODER_STATS_EN
    , .stat_decoded(stat_decoded), .stat_illegal(stat_illegal)
`endif
  );

  typedef struct {
    int          op;
    int          rs1, rs2, rd, shamt;
    logic [31:0] imm, pc;
    bit          use_imm, illegal;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   n_dec = 0;
  int   n_ill = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Reference decode: table lookup plus offset arithmetic straight from the ISA field layout.
  function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int alu_tab[8] = '{0, 2, 13, -1, 6, 4, 7, 8};
    int br_tab[8]  = '{9, 10, -1, -1, 11, 12, -1, -1};
    int f3 = int'(ins[14:12]);
    int f7 = int'(ins[31:25]);
    int opc = int'(ins[6:0]);
    e.rs1 = int'(ins[19:15]); e.rs2 = int'(ins[24:20]); e.rd = int'(ins[11:7]);
    e.pc = pc; e.op = 0; e.imm = 0; e.shamt = 0; e.use_imm = 0; e.illegal = 1;
    if (opc == 'h33 && alu_tab[f3] >= 0 &&
        (f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5)))) begin
      e.illegal = 0;
      e.op = alu_tab[f3] + (f7 == 32 ? 1 : 0);
    end else if (opc == 'h13 && alu_tab[f3] >= 0) begin
      e.illegal = 0;
      e.use_imm = 1;
      e.op = alu_tab[f3] + ((f3 == 5 && ins[30]) ? 1 : 0);
      e.imm = 32'(int'(ins[31:20]) - (ins[31] ? 4096 : 0));
      if (f3 == 1 || f3 == 5) e.shamt = int'(ins[24:20]);
    end else if (opc == 'h63 && br_tab[f3] >= 0) begin
      e.illegal = 0;
      e.op = br_tab[f3];
      e.rd = 0;
      e.imm = 32'((ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 +
                  int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2);
    end
    return e;
  endfunction

  task automatic check_state();
    exp_t e;
    chk("count", 32'(count), 32'(q.size()));
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    if (q.size() != 0) begin
      e = q[0];
      chk("op", 32'(out_op), 32'(e.op));
      chk("rs1", 32'(out_rs1), 32'(e.rs1));
      chk("rs2", 32'(out_rs2), 32'(e.rs2));
      chk("rd", 32'(out_rd), 32'(e.rd));
      chk("imm", out_imm, e.imm);
      chk("use_imm", 32'(out_use_imm), 32'(e.use_imm));
      chk("shamt", 32'(out_shamt), 32'(e.shamt));
      chk("illegal", 32'(out_illegal), 32'(e.illegal));
      chk("pc", out_pc, e.pc);
    end
`ifdef ALU_ISSUE_DECODER_STATS_EN
    chk("stat_decoded", stat_decoded, 32'(n_dec));
    chk("stat_illegal", stat_illegal, 32'(n_ill));
`endif
  endtask

  // Inputs are set at a negedge; the model predicts the coming posedge, then the DUT is checked at the next negedge.
  task automatic cycle();
    exp_t e, junk;
    bit can_push, can_pop;
    can_push = in_valid && (q.size() != DEPTH);
    can_pop  = out_ready && (q.size() != 0);
    if (flush) q.delete();
    else begin
      if (can_pop) junk = q.pop_front();
      if (can_push) begin
        e = ref_dec(in_instr, in_pc);
        q.push_back(e);
        if (e.illegal) n_ill++;
        else n_dec++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input bit rdy);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = $urandom;
    out_ready = rdy;
    flush     = 1'b0;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] ins = $urandom;
    int sel = $urandom_range(0, 9);
    int f7sel = $urandom_range(0, 3);
    if (sel < 4) begin
      ins[6:0] = 7'h33;
      if (f7sel < 2) ins[31:25] = 7'h00;
      else if (f7sel == 2) ins[31:25] = 7'h20;
    end else if (sel < 7) ins[6:0] = 7'h13;
    else if (sel < 9) ins[6:0] = 7'h63;
    return ins;
  endfunction

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    #12;
    check_state();
    chk("rst_op", 32'(out_op), 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    drive(1'b1, 32'h002081B3, 1'b0); cycle();
    chk("add_op", 32'(out_op), 32'd0);
    chk("add_rd", 32'(out_rd), 32'd3);
    chk("add_cnt", 32'(count), 32'd1);

    drive(1'b1, 32'h40735293, 1'b0); cycle();
    drive(1'b1, 32'h403100B3, 1'b0); cycle();
    drive(1'b0, 32'h0, 1'b1); cycle();
    drive(1'b0, 32'h0, 1'b0); cycle();
    chk("srai_op", 32'(out_op), 32'd5);
    chk("srai_use_imm", 32'(out_use_imm), 32'd1);
    chk("srai_shamt", 32'(out_shamt), 32'd7);
    drive(1'b0, 32'h0, 1'b1); cycle();
    chk("sub_op", 32'(out_op), 32'd1);
    cycle();

    drive(1'b1, 32'hFE20DCE3, 1'b0); cycle();
    chk("bge_op", 32'(out_op), 32'd12);
    chk("bge_imm", out_imm, 32'hFFFFFFF8);
    chk("bge_rd", 32'(out_rd), 32'd0);
    drive(1'b1, 32'h0020B1B3, 1'b1); cycle();
    chk("sltu_ill", 32'(out_illegal), 32'd1);
    chk("sltu_op", 32'(out_op), 32'd0);
    drive(1'b0, 32'h0, 1'b1); cycle();

    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, rand_instr(), 1'b0); cycle();
    end
    chk("full_rdy", 32'(in_ready), 32'd0);
    drive(1'b1, rand_instr(), 1'b1); cycle();
    chk("full_pop_only", 32'(count), 32'd3);
    drive(1'b1, rand_instr(), 1'b0); cycle();
    chk("refill", 32'(count), 32'd4);

    drive(1'b0, 32'h0, 1'b1); cycle(); cycle();
    drive(1'b1, 32'h002081B3, 1'b1); flush = 1'b1; cycle();
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_vld", 32'(out_valid), 32'd0);
    drive(1'b0, 32'h0, 1'b1); cycle();

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      cycle();
    end

    drive(1'b0, 32'h0, 1'b1); cycle(); cycle(); cycle(); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, rand_instr(), 1'b0); cycle();
    end
    drive(1'b1, rand_instr(), 1'b1);
    #2 rst_n = 1'b0;
    #1;
    q.delete();
    n_dec = 0;
    n_ill = 0;
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_cnt", 32'(count), 32'd0);
    chk("arst_op", 32'(out_op), 32'd0);
    check_state();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive($urandom_range(0, 1) != 0, rand_instr(), $urandom_range(0, 1) != 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
